// File: rtl/genius_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | genius_pkg: colour encoding, playback states and LFSR constants shared by |
// | the Genius game blocks.                                   Revision: 1.0  |
// +--------------------------------------------------------------------------+
package genius_pkg;

  localparam logic [1:0] VERDE_C    = 2'd0;
  localparam logic [1:0] VERMELHO_C = 2'd1;
  localparam logic [1:0] AZUL_C     = 2'd2;
  localparam logic [1:0] AMARELO_C  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } play_state_t;

  // Bit positions 15,13,12,10 realise x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr16: free-running 16-bit Fibonacci LFSR, loaded with SEED on reset.    |
// |                                                           Revision: 1.0  |
// +--------------------------------------------------------------------------+
module lfsr16
  import genius_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign q = r_state;

endmodule
`default_nettype wire

// File: rtl/seq_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_player: stores the Genius colour sequence, appends random colours and |
// | plays the sequence as timed cor/enable steps.             Revision: 1.0  |
// +--------------------------------------------------------------------------+
module seq_player
  import genius_pkg::*;
#(
  parameter int          MAX_LEN   = 32,
  parameter int          ON_TICKS  = 50000000,
  parameter int          GAP_TICKS = 25000000,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       add,
  input  logic                       play,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [1:0]                 rd_cor,
  output logic [$clog2(MAX_LEN):0]   len,
  output logic                       full,
  output logic [1:0]                 cor,
  output logic                       enable,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CNT_W = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);

  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr;
  logic             w_add;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] w_idx_nxt;

  logic [1:0]       r_mem [MAX_LEN];
  play_state_t      r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_plen;
  logic [LEN_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  logic [1:0]       r_cor;
  logic             r_enable;
  logic             r_busy;
  logic             r_done;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (w_lfsr)
  );

  // Only the two low bits pick a colour; the rest feed the shift register.
  assign w_unused_lfsr = ^w_lfsr[15:2];

  assign w_add     = (r_state == ST_IDLE) && add && !clear && !play && !r_full;
  assign w_len_nxt = r_len + LEN_W'(1);
  assign w_idx_nxt = r_idx + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst && w_add) begin
      r_mem[r_len[IDX_W-1:0]] <= w_lfsr[1:0];
    end
  end

  assign rd_cor = r_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_plen   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_cor    <= VERDE_C;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_len  <= '0;
            r_full <= 1'b0;
          end else if (play) begin
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_plen   <= r_len;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              r_enable <= 1'b1;
              r_cor    <= r_mem[0];
              r_cnt    <= ON_LOAD;
              r_state  <= ST_ON;
            end
          end else if (w_add) begin
            r_len  <= w_len_nxt;
            r_full <= (w_len_nxt == MAX_LEN_L);
          end
        end
        ST_ON: begin
          if (r_cnt == '0) begin
            r_enable <= 1'b0;
            r_cnt    <= GAP_LOAD;
            r_state  <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == r_plen) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_enable <= 1'b1;
              r_cor    <= r_mem[w_idx_nxt[IDX_W-1:0]];
              r_cnt    <= ON_LOAD;
              r_state  <= ST_ON;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign len    = r_len;
  assign full   = r_full;
  assign cor    = r_cor;
  assign enable = r_enable;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: doc/seq_player.md
Name: seq_player

Overview:
- Upstream neighbour of the LED controller in the Genius game.
- Holds the growing colour sequence for the current game and appends one pseudo-random colour per round from an internal LFSR.
- On request, plays the stored sequence as timed `cor`/`enable` steps that drive the LED controller directly.
- Exposes a read port so the input-checking logic can compare player presses against the stored sequence.

Parameters:
- MAX_LEN, 32: sequence capacity in colours; power of 2, at most 64.
- ON_TICKS, 50000000: clk cycles each colour is lit (0.5 s at 100 MHz).
- GAP_TICKS, 25000000: clk cycles dark between colours.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- clear  in  1  pulse: empty the sequence (new game).
- add  in  1  pulse: append one random colour.
- play  in  1  pulse: start playback of the whole sequence.
- rd_idx  in  $clog2(MAX_LEN)  checker read index.
- rd_cor  out  2  colour at rd_idx; combinational read.
- len  out  $clog2(MAX_LEN)+1  number of stored colours.
- full  out  1  len == MAX_LEN.
- cor  out  2  colour to the LED controller: 0 green, 1 red, 2 blue, 3 yellow.
- enable  out  1  LED controller enable; high while a colour is lit.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse when playback ends.

Behaviour:
- Reset values (when rst=1 at a clk edge): state IDLE, len=0, lfsr=SEED, cor=0, enable=0, busy=0, done=0, tick counter=0, idx=0. Memory contents are not reset.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1).
  - Shifts every cycle while not in reset: new bit = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], shifted into bit 0.
  - Player timing therefore randomises the sequence.
- Command priority, evaluated only in IDLE: clear > play > add. Commands arriving while busy are ignored and not queued.
- clear: len <= 0. Memory is not erased.
- add:
  - If len < MAX_LEN: mem[len] <= lfsr[1:0] using the current-cycle LFSR value, then len <= len+1.
  - If full: ignored; len and memory unchanged.
- play with len == 0: done=1 on the next cycle. No enable pulse, busy stays 0.
- play with len > 0: playback FSM runs IDLE -> ON -> GAP -> (ON | FIN) -> IDLE.
  - IDLE: on play, latch the current len as plen, idx <= 0, busy <= 1, go to ON.
  - ON: enable=1, cor=mem[idx], held for exactly ON_TICKS cycles, then go to GAP.
  - GAP: enable=0, cor holds its last value, held for exactly GAP_TICKS cycles. Then idx <= idx+1; if idx+1 == plen go to FIN, else go to ON.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- Latency: play sampled at edge k -> enable=1 from cycle k+1 through k+ON_TICKS.
- Total playback duration: plen*(ON_TICKS+GAP_TICKS)+1 cycles from play to done.
- Tick counter: down-counter sized $clog2(max(ON_TICKS,GAP_TICKS)). Loaded with N-1 on state entry; the state exits when it reaches 0.
- rst mid-playback: next cycle all outputs are at their reset values and the sequence is emptied (len=0).
- All outputs except rd_cor are registered.

Decomposition:
- Shared package genius_pkg holds:
  - colour constants VERDE_C=0, VERMELHO_C=1, AZUL_C=2, AMARELO_C=3 (the 2-bit `cor` encoding);
  - the playback state enum;
  - LFSR_TAPS and the default SEED.
- One sub-module: lfsr16 (clk, rst, seed param, q[15:0]). Free-running, reusable by other game blocks.
- Sequence memory and the FSM stay in seq_player.

Test Plan (simulation parameters ON_TICKS=4, GAP_TICKS=2, MAX_LEN=4):
- Reset then 3 add pulses on consecutive cycles -> len=3. rd_idx 0..2 return lfsr[1:0] values predicted by a bench LFSR model seeded 16'hACE1 and advanced the same number of cycles.
- play with len=3 -> enable waveform 1111 00 1111 00 1111 00 with cor matching mem[0..2]. done is a single pulse exactly 19 cycles after play. busy is high throughout the 18 playback cycles.
- play with len=0 -> done pulse at play+1, enable never high, busy never high.
- 5 add pulses -> len=4, full=1, fifth add ignored, mem[0..3] unchanged.
- During playback, assert clear, add and play -> all ignored: len unchanged, playback timing identical to the undisturbed run. Same-cycle clear+add in IDLE -> len=0.
- rst asserted during an ON phase -> next cycle enable=0, busy=0, len=0, done never pulses.
